program_loader: RTL and testbench

Byte-serial boot loader that fills the CPU's instruction memory before the fetch/execute control unit starts running. It accepts a framed byte stream on a valid/ready interface and packs bytes into 32-bit instruction words (opcode in [31:28], Rd in [27:25], 16-bit immediate in [15:0]). It writes the words to consecutive instruction-memory addresses from 0 and holds the CPU in reset until a frame with a valid checksum has been written.

---
 rtl/program_loader.sv | 167 ++++++++++++++++
 tb/tb_program_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: byte-serial boot loader. Parses framed byte streams, packs bytes into
// 32-bit instruction words, writes them to instruction memory and releases the CPU on a good checksum.
module program_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [8:0]        words_loaded
);
    localparam int unsigned   CNT_W     = 9;
    localparam longint unsigned MAX_WORDS = 64'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [7:0]         csum_q, csum_d;
    logic [23:0]        asm_q, asm_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               load_done_q, load_done_d;
    logic               load_error_q, load_error_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [CNT_W-1:0]   words_next;
    logic               accept;

    assign accept     = in_valid && in_ready_q;
    assign words_next = words_q + CNT_W'(1);

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        csum_d       = csum_q;
        asm_d        = asm_q;
        byte_cnt_d   = byte_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        words_d      = words_q;

        if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_data == HEADER) state_d = S_COUNT;
                end
                S_COUNT: begin
                    if (in_data == 8'd0 || 64'(in_data) > MAX_WORDS) begin
                        state_d      = S_ERROR;
                        load_error_d = 1'b1;
                    end else begin
                        n_d        = CNT_W'(in_data);
                        csum_d     = in_data;
                        words_d    = '0;
                        byte_cnt_d = 2'd0;
                        state_d    = S_DATA;
                    end
                end
                S_DATA: begin
                    asm_d      = {asm_q[15:0], in_data};
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ADDR_W'(words_q);
                        imem_wdata_d = {asm_q, in_data};
                        words_d      = words_next;
                        if (words_next == n_q) state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (in_data == csum_q) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d      = S_ERROR;
                        load_error_d = 1'b1;
                    end
                end
                S_DONE: begin
                    if (in_data == HEADER) begin
                        state_d     = S_COUNT;
                        cpu_hold_d  = 1'b1;
                        load_done_d = 1'b0;
                    end
                end
                S_ERROR: begin
                    if (in_data == HEADER) begin
                        state_d      = S_COUNT;
                        load_error_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Stall the stream exactly in the write cycle
        in_ready_d = !imem_we_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            csum_q       <= '0;
            asm_q        <= '0;
            byte_cnt_q   <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            csum_q       <= csum_d;
            asm_q        <= asm_d;
            byte_cnt_q   <= byte_cnt_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            words_q      <= words_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: frame-level reference model checked every cycle,
// directed frames with literal expectations, and randomized frames with stream gaps.
module tb_program_loader;
    localparam int unsigned ADDR_W = 2;
    localparam logic [7:0]  HEADER = 8'hA5;
    localparam int          MAXW   = 1 << ADDR_W;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b1;
    logic [7:0]        in_data  = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;
    logic [8:0]        words_loaded;

    program_loader #(.ADDR_W(ADDR_W), .HEADER(HEADER)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs derived from the bytes of the frame seen so far
    logic              e_ready, e_we, e_hold, e_done, e_err;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_wdata;
    logic [8:0]        e_words;
    logic [7:0]        fq[$];
    bit                in_frame;
    int                m_sz, m_n, m_k;
    logic [7:0]        m_x;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            e_ready = 1'b1; e_we = 1'b0; e_addr = '0; e_wdata = '0;
            e_hold = 1'b1; e_done = 1'b0; e_err = 1'b0; e_words = '0;
            in_frame = 1'b0; fq.delete();
        end else begin
            bit acc;
            acc  = in_valid && e_ready;
            e_we = 1'b0;
            if (acc) begin
                if (!in_frame) begin
                    if (in_data == HEADER) begin
                        in_frame = 1'b1;
                        fq.delete();
                        e_err  = 1'b0;
                        e_hold = 1'b1;
                        e_done = 1'b0;
                    end
                end else begin
                    fq.push_back(in_data);
                    m_sz = fq.size();
                    m_n  = int'(fq[0]);
                    if (m_sz == 1) begin
                        if (m_n == 0 || m_n > MAXW) begin
                            e_err = 1'b1; in_frame = 1'b0;
                        end else e_words = '0;
                    end else if (m_sz <= 4 * m_n + 1) begin
                        m_k = m_sz - 1;
                        if (m_k % 4 == 0) begin
                            e_we    = 1'b1;
                            e_addr  = ADDR_W'(m_k / 4 - 1);
                            e_wdata = {fq[m_k-3], fq[m_k-2], fq[m_k-1], fq[m_k]};
                            e_words = 9'(m_k / 4);
                        end
                    end else begin
                        m_x = 8'h00;
                        for (int i = 0; i < m_sz - 1; i++) m_x = m_x ^ fq[i];
                        if (in_data == m_x) begin
                            e_done = 1'b1; e_hold = 1'b0;
                        end else e_err = 1'b1;
                        in_frame = 1'b0;
                    end
                end
            end
            e_ready = !e_we;
        end
    end

    // Per-cycle comparison against the model, plus capture of memory writes
    logic [31:0] cap [MAXW];
    int          we_cnt    = 0;
    int          ready_bad = 0;

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("in_ready",     32'(in_ready),     32'(e_ready));
            chk("imem_we",      32'(imem_we),      32'(e_we));
            chk("imem_addr",    32'(imem_addr),    32'(e_addr));
            chk("imem_wdata",   imem_wdata,        e_wdata);
            chk("cpu_hold",     32'(cpu_hold),     32'(e_hold));
            chk("load_done",    32'(load_done),    32'(e_done));
            chk("load_error",   32'(load_error),   32'(e_err));
            chk("words_loaded", 32'(words_loaded), 32'(e_words));
            if (imem_we === 1'b1) begin
                cap[imem_addr] = imem_wdata;
                we_cnt++;
                if (in_ready !== 1'b0) ready_bad++;
            end
        end
    end

    // Caller is positioned just after a rising edge; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        bit acc;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        acc = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0; in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = b;
        for (int t = 0; t < 8 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_data = 8'($urandom);
        chk("byte_accepted", 32'(acc), 32'd1);
    endtask

    task automatic send_list(input logic [7:0] q[$], input int gap_max);
        foreach (q[i]) send_byte(q[i], gap_max);
    endtask

    task automatic send_frame(input int n, input logic [31:0] w [4], input bit bad, input int gap_max);
        logic [7:0] q[$];
        logic [7:0] cs;
        logic [7:0] b;
        q.push_back(HEADER);
        q.push_back(8'(n));
        cs = 8'(n);
        if (n >= 1 && n <= MAXW) begin
            for (int i = 0; i < n; i++)
                for (int j = 3; j >= 0; j--) begin
                    b = w[i][8*j +: 8];
                    q.push_back(b);
                    cs = cs ^ b;
                end
            q.push_back(bad ? ~cs : cs);
        end
        send_list(q, gap_max);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),     32'd1);
        chk({tag, "_imem_we"},    32'(imem_we),      32'd0);
        chk({tag, "_imem_addr"},  32'(imem_addr),    32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata,        32'd0);
        chk({tag, "_cpu_hold"},   32'(cpu_hold),     32'd1);
        chk({tag, "_load_done"},  32'(load_done),    32'd0);
        chk({tag, "_load_error"}, 32'(load_error),   32'd0);
        chk({tag, "_words"},      32'(words_loaded), 32'd0);
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [31:0] w [4];
        int          w0;

        foreach (cap[i]) cap[i] = '0;
        #1 reset_n = 1'b0;
        cmp_en = 1'b1;
        #1 chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Single word frame
        w0 = we_cnt;
        q = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h00, 8'h05, 8'h24};
        send_list(q, 0);
        @(negedge clk);
        chk("single_data",  cap[0], 32'h2000_0005);
        chk("single_writes", 32'(we_cnt - w0), 32'd1);
        chk("single_done",  32'(load_done), 32'd1);
        chk("single_hold",  32'(cpu_hold), 32'd0);
        chk("single_words", 32'(words_loaded), 32'd1);
        @(posedge clk); #1;

        // Bad checksum
        q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        send_list(q, 0);
        @(negedge clk);
        chk("badcs_data",  cap[0], 32'h1234_5678);
        chk("badcs_error", 32'(load_error), 32'd1);
        chk("badcs_hold",  32'(cpu_hold), 32'd1);
        chk("badcs_done",  32'(load_done), 32'd0);
        @(posedge clk); #1;

        // Zero and oversize counts
        w0 = we_cnt;
        q = '{8'hA5, 8'h00};
        send_list(q, 0);
        @(negedge clk);
        chk("zero_error", 32'(load_error), 32'd1);
        @(posedge clk); #1;
        send_byte(HEADER, 0);
        @(negedge clk);
        chk("hdr_clears_error", 32'(load_error), 32'd0);
        @(posedge clk); #1;
        send_byte(8'h05, 0);
        @(negedge clk);
        chk("oversize_error",  32'(load_error), 32'd1);
        chk("bad_count_writes", 32'(we_cnt - w0), 32'd0);
        @(posedge clk); #1;

        // Reset after the 6th data byte of a 4-word frame
        q = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_list(q, 0);
        reset_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Preamble garbage, then a 2-word frame, then a restart header
        foreach (cap[i]) cap[i] = '0;
        w0 = we_cnt;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        w = '{32'h1122_3344, 32'hA0B0_C0D0, 32'h0, 32'h0};
        send_frame(2, w, 1'b0, 0);
        @(negedge clk);
        chk("pre_addr0",  cap[0], 32'h1122_3344);
        chk("pre_addr1",  cap[1], 32'hA0B0_C0D0);
        chk("pre_writes", 32'(we_cnt - w0), 32'd2);
        chk("pre_done",   32'(load_done), 32'd1);
        @(posedge clk); #1;
        send_byte(HEADER, 0);
        @(negedge clk);
        chk("restart_hold", 32'(cpu_hold), 32'd1);
        chk("restart_done", 32'(load_done), 32'd0);
        @(posedge clk); #1;
        send_byte(8'h00, 0);

        // 4-word frame with random stream gaps
        foreach (cap[i]) cap[i] = '0;
        w0 = we_cnt;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        send_frame(4, w, 1'b0, 3);
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("gap_addr%0d", i), cap[i], w[i]);
        chk("gap_writes", 32'(we_cnt - w0), 32'd4);
        chk("gap_done",   32'(load_done), 32'd1);
        @(posedge clk); #1;

        // Randomized frames: counts 0..5, occasional corrupt checksum and garbage
        for (int f = 0; f < 25; f++) begin
            int n;
            n = int'($urandom_range(5, 0));
            if (n == 0 && $urandom_range(1, 0) == 0) n = 3;
            for (int i = 0; i < 4; i++) w[i] = $urandom;
            if ($urandom_range(3, 0) == 0) send_byte(8'($urandom), 2);
            send_frame(n, w, $urandom_range(3, 0) == 0, 3);
        end
        repeat (3) @(posedge clk);
        #1;

        chk("ready_low_only_on_write", 32'(ready_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
